md_ctrl: RTL and testbench

Sequencing controller for the multiply/divide datapath in the execute stage. It accepts MULT/MULTU/DIV/DIVU and HI/LO move operations, launches the fixed-latency datapath and owns the architectural HI/LO registers. It tracks completion and generates the pipeline stall for dependent HI/LO accesses. A pipeline flush cancels an in-flight operation without corrupting HI/LO.

---
 rtl/md_pkg.sv | 43 ++++
 rtl/md_if.sv | 36 +++
 rtl/md_lat_cnt.sv | 31 +++
 rtl/md_ctrl.sv | 123 ++++++++++++
 tb/tb_md_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Op codes, FSM state type and default latencies for md_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 30;

    localparam logic [3:0] OP_MFHI  = 4'b0001;
    localparam logic [3:0] OP_MFLO  = 4'b0010;
    localparam logic [3:0] OP_MTHI  = 4'b0011;
    localparam logic [3:0] OP_MTLO  = 4'b0100;
    localparam logic [3:0] OP_MULT  = 4'b0101;
    localparam logic [3:0] OP_MULTU = 4'b0110;
    localparam logic [3:0] OP_DIVU  = 4'b0111;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_launch(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || op_is_div(op);
    endfunction

    // Every op that touches HI/LO or the datapath; only these can stall.
    function automatic logic op_is_md(input logic [3:0] op);
        return op_is_launch(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
// Module      : md_if
// Description : EX-stage op bus plus datapath launch/result bus of md_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             flush;
    logic             stall;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dp_go;
    logic [3:0]       dp_m;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_hi;
    logic [WIDTH-1:0] dp_lo;

    modport master (
        output op_valid, op, rs, rt, flush, dp_hi, dp_lo,
        input  stall, rdata, hi_q, lo_q, dp_go, dp_m, dp_a, dp_b
    );

    modport slave (
        input  op_valid, op, rs, rt, flush, dp_hi, dp_lo,
        output stall, rdata, hi_q, lo_q, dp_go, dp_m, dp_a, dp_b
    );
endinterface
`default_nettype wire

// File: rtl/md_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : md_lat_cnt
// Description : 6-bit loadable down counter flagging the last latency cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module md_lat_cnt (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       load_i,
    input  wire logic       en_i,
    input  wire logic [5:0] load_val_i,
    output logic      [5:0] count_o,
    output logic            done_o
);
    logic [5:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 6'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != 6'd0)) begin
            count_q <= count_q - 6'd1;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == 6'd1) & ~load_i;
endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl
// Description : Multiply/divide sequencer owning HI/LO and the EX-stage stall.
// Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH   = MD_WIDTH,
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  wire logic clk,
    input  wire logic rst,
    md_if.slave       md_s
);
    localparam logic [5:0] C_MUL_LAT = 6'(MUL_LAT);
    localparam logic [5:0] C_DIV_LAT = 6'(DIV_LAT);

    md_state_e        state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] dp_a_q;
    logic [WIDTH-1:0] dp_b_q;
    logic [3:0]       dp_m_q;
    logic             dp_go_q;

    logic             op_act;
    logic             accept;
    logic             launch;
    logic             cnt_en;
    logic             cnt_done;
    logic             finish;
    logic [5:0]       cnt;
    logic [5:0]       lat_sel;
    logic [WIDTH-1:0] rdata_d;

    assign op_act  = md_s.op_valid & ~md_s.flush;
    assign accept  = op_act & (state_q == ST_IDLE);
    assign launch  = accept & op_is_launch(md_s.op);
    assign lat_sel = op_is_div(md_s.op) ? C_DIV_LAT : C_MUL_LAT;

    // The counter holds during the dp_go cycle so completion lands on E1+LAT.
    assign cnt_en  = (state_q != ST_IDLE) & ~dp_go_q;
    assign finish  = cnt_done & cnt_en;

    md_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (launch),
        .en_i       (cnt_en),
        .load_val_i (lat_sel),
        .count_o    (cnt),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            dp_m_q  <= 4'b0000;
            dp_go_q <= 1'b0;
        end else begin
            dp_go_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q <= ST_BUSY;
                        dp_go_q <= 1'b1;
                        dp_m_q  <= md_s.op;
                        dp_a_q  <= md_s.rs;
                        dp_b_q  <= md_s.rt;
                    end else if (accept && (md_s.op == OP_MTHI)) begin
                        hi_q <= md_s.rs;
                    end else if (accept && (md_s.op == OP_MTLO)) begin
                        lo_q <= md_s.rs;
                    end
                end
                ST_BUSY: begin
                    if (md_s.flush) begin
                        state_q <= ST_DRAIN;
                    end else if (finish) begin
                        hi_q    <= md_s.dp_hi;
                        lo_q    <= md_s.dp_lo;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // A flush on the completion cycle arrives here with the count already spent.
                    if (finish || (cnt == 6'd0)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (!rst && md_s.op_valid) begin
            case (md_s.op)
                OP_MFHI: rdata_d = hi_q;
                OP_MFLO: rdata_d = lo_q;
                default: rdata_d = '0;
            endcase
        end
    end

    assign md_s.stall = ~rst & op_act & (state_q != ST_IDLE) & op_is_md(md_s.op);
    assign md_s.rdata = rdata_d;
    assign md_s.hi_q  = hi_q;
    assign md_s.lo_q  = lo_q;
    assign md_s.dp_go = dp_go_q;
    assign md_s.dp_m  = dp_m_q;
    assign md_s.dp_a  = dp_a_q;
    assign md_s.dp_b  = dp_b_q;
endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_ctrl
// Description : Randomized self-checking bench for md_ctrl with datapath model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;
    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 30;

    localparam logic [3:0] C_MFHI = 4'b0001, C_MFLO = 4'b0010, C_MTHI = 4'b0011,
                           C_MTLO = 4'b0100, C_MULT = 4'b0101, C_MULTU = 4'b0110,
                           C_DIVU = 4'b0111, C_DIV = 4'b1011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    md_if #(.WIDTH(W)) bus ();
    md_ctrl #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (.clk(clk), .rst(rst), .md_s(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- architectural reference ----------------
    function automatic logic tb_is_div(input logic [3:0] op);
        return (op == C_DIV) || (op == C_DIVU);
    endfunction
    function automatic logic tb_is_launch(input logic [3:0] op);
        return (op == C_MULT) || (op == C_MULTU) || tb_is_div(op);
    endfunction
    function automatic logic tb_uses_md(input logic [3:0] op);
        return tb_is_launch(op) || (op >= C_MFHI && op <= C_MTLO);
    endfunction

    // Returns {HI, LO}; divide by zero yields {dividend, all-ones}.
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, m;
        logic [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = 64'd0;
        case (op)
            C_MULT:  r = sa * sb;
            C_MULTU: r = {32'd0, a} * {32'd0, b};
            C_DIV:   if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                     else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
            C_DIVU:  if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                     else r = {a % b, a / b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Datapath: result valid only in the cycle just before edge E1+LAT, junk otherwise.
    int          dp_rem = 0;
    logic [63:0] dp_res = 64'd0;
    always @(posedge clk) begin
        if (bus.dp_go) begin
            dp_res = ref_res(bus.dp_m, bus.dp_a, bus.dp_b);
            dp_rem = tb_is_div(bus.dp_m) ? DL : ML;
        end else if (dp_rem > 0) begin
            dp_rem = dp_rem - 1;
        end
        #1;
        if (dp_rem == 1) {bus.dp_hi, bus.dp_lo} = dp_res;
        else             {bus.dp_hi, bus.dp_lo} = {$urandom, $urandom};
    end

    // ---------------- transaction-level model ----------------
    logic        m_busy, m_drain;
    int          m_end, m_go;
    logic [31:0] m_hi, m_lo, p_hi, p_lo, m_a, m_b;
    logic [3:0]  m_m;

    logic        exp_stall, obs_stall;
    logic [31:0] exp_rdata, obs_rdata;
    int          cyc_bad;
    string       bad_msg;

    function automatic void model_reset();
        m_busy = 1'b0; m_drain = 1'b0; m_end = 0; m_go = -1;
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_a = '0; m_b = '0; m_m = 4'd0;
    endfunction

    function automatic void note(input string s);
        cyc_bad++;
        if (bad_msg == "") bad_msg = s;
    endfunction

    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
        logic e_go;
        bus.op_valid = v; bus.op = op; bus.rs = a; bus.rt = b; bus.flush = fl;
        #3;
        exp_stall = v && m_busy && tb_uses_md(op) && !fl;
        exp_rdata = (v && op == C_MFHI) ? m_hi : (v && op == C_MFLO) ? m_lo : 32'd0;
        e_go      = (cyc == m_go);
        obs_stall = bus.stall;
        obs_rdata = bus.rdata;
        if (obs_stall !== exp_stall) note($sformatf("cyc %0d stall=%b want %b", cyc, obs_stall, exp_stall));
        if (obs_rdata !== exp_rdata) note($sformatf("cyc %0d rdata=%h want %h", cyc, obs_rdata, exp_rdata));
        if (bus.dp_go !== e_go)      note($sformatf("cyc %0d dp_go=%b want %b", cyc, bus.dp_go, e_go));
        if (bus.hi_q !== m_hi)       note($sformatf("cyc %0d hi_q=%h want %h", cyc, bus.hi_q, m_hi));
        if (bus.lo_q !== m_lo)       note($sformatf("cyc %0d lo_q=%h want %h", cyc, bus.lo_q, m_lo));
        if (bus.dp_a !== m_a || bus.dp_b !== m_b || bus.dp_m !== m_m)
            note($sformatf("cyc %0d dp_a/b/m=%h/%h/%h want %h/%h/%h", cyc, bus.dp_a, bus.dp_b, bus.dp_m, m_a, m_b, m_m));
        if (fl && m_busy) begin
            m_drain = 1'b1;
        end else if (v && !fl && !m_busy) begin
            if (tb_is_launch(op)) begin
                {p_hi, p_lo} = ref_res(op, a, b);
                m_busy = 1'b1; m_drain = 1'b0;
                m_go   = cyc + 1;
                m_end  = cyc + 2 + (tb_is_div(op) ? DL : ML);
                m_a = a; m_b = b; m_m = op;
            end else if (op == C_MTHI) m_hi = a;
            else if (op == C_MTLO)     m_lo = a;
        end
        @(posedge clk); #1;
        if (m_busy && cyc >= m_end) begin
            if (!m_drain) begin m_hi = p_hi; m_lo = p_lo; end
            m_busy = 1'b0;
        end
    endtask

    // Presents one op and holds it while stalled, like the EX stage would.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic [31:0] rd);
        stalls = 0;
        step(1'b1, op, a, b, 1'b0);
        while (exp_stall && stalls < 200) begin
            stalls++;
            step(1'b1, op, a, b, 1'b0);
        end
        rd = obs_rdata;
    endtask

    task automatic begin_test();
        cyc_bad = 0;
        bad_msg = "";
    endtask

    task automatic end_test(input string name);
        n_checks++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL %s cycle checks: %0d bad, first: %s", name, cyc_bad, bad_msg);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.op_valid = 1'b1; bus.op = C_MFHI; bus.rs = $urandom; bus.rt = $urandom; bus.flush = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #4;
        n_checks++; if (bus.stall !== 1'b0)   begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        n_checks++; if (bus.rdata !== 32'd0)  begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        n_checks++; if (bus.hi_q !== 32'd0 || bus.lo_q !== 32'd0)
            begin n_fail++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi_q, bus.lo_q); end
        n_checks++; if (bus.dp_go !== 1'b0 || bus.dp_m !== 4'd0 || bus.dp_a !== 32'd0 || bus.dp_b !== 32'd0)
            begin n_fail++; $display("FAIL reset_dp got go=%b m=%h a=%h b=%h want zeros", bus.dp_go, bus.dp_m, bus.dp_a, bus.dp_b); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_mult_dep();
        int st; logic [31:0] rd;
        begin_test();
        step(1'b1, C_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
        n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL mult_launch_stall got %b want 0", obs_stall); end
        issue(C_MFHI, 32'd0, 32'd0, st, rd);
        // MFHI sits in cycle E0, so it stalls from E0 through E1+LAT-1.
        n_checks++; if (st !== ML + 1) begin n_fail++; $display("FAIL mult_stall_cycles got %0d want %0d", st, ML + 1); end
        n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_mfhi got %h want ffffffff", rd); end
        n_checks++; if (bus.lo_q !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo_q); end
        end_test("mult_dep");
    endtask

    task automatic test_div();
        int st; logic [31:0] rd, a, b; logic [3:0] op; logic [63:0] r;
        begin_test();
        step(1'b1, C_DIVU, 32'd100, 32'd7, 1'b0);
        issue(C_MFLO, 32'd0, 32'd0, st, rd);
        n_checks++; if (st !== DL + 1) begin n_fail++; $display("FAIL divu_stall_cycles got %0d want %0d", st, DL + 1); end
        n_checks++; if (rd !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %0d want 14", rd); end
        n_checks++; if (bus.hi_q !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %0d want 2", bus.hi_q); end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: op = C_MULT;
                1: op = C_MULTU;
                2: op = C_DIV;
                default: op = C_DIVU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            r = ref_res(op, a, b);
            issue(op, a, b, st, rd);
            issue(C_MFHI, 32'd0, 32'd0, st, rd);
            n_checks++; if (rd !== r[63:32]) begin n_fail++; $display("FAIL rand_hi op=%h a=%h b=%h got %h want %h", op, a, b, rd, r[63:32]); end
            issue(C_MFLO, 32'd0, 32'd0, st, rd);
            n_checks++; if (rd !== r[31:0]) begin n_fail++; $display("FAIL rand_lo op=%h a=%h b=%h got %h want %h", op, a, b, rd, r[31:0]); end
        end
        end_test("div");
    endtask

    task automatic test_mthi();
        int st1, st2; logic [31:0] rd, v;
        begin_test();
        issue(C_MTHI, 32'h1234, 32'd0, st1, rd);
        issue(C_MFHI, 32'd0, 32'd0, st2, rd);
        n_checks++; if (st1 !== 0 || st2 !== 0) begin n_fail++; $display("FAIL mthi_stall got %0d/%0d want 0/0", st1, st2); end
        n_checks++; if (rd !== 32'h1234) begin n_fail++; $display("FAIL mthi_mfhi got %h want 00001234", rd); end
        v = $urandom;
        issue(C_MTLO, v, 32'd0, st1, rd);
        issue(C_MFLO, 32'd0, 32'd0, st2, rd);
        n_checks++; if (rd !== v) begin n_fail++; $display("FAIL mtlo_mflo got %h want %h", rd, v); end
        end_test("mthi");
    endtask

    task automatic test_flush_idle();
        int st; logic [31:0] rd, x;
        begin_test();
        x = $urandom;
        issue(C_MTHI, x, 32'd0, st, rd);
        step(1'b1, C_MTHI, ~x, 32'd0, 1'b1);
        issue(C_MFHI, 32'd0, 32'd0, st, rd);
        n_checks++; if (rd !== x) begin n_fail++; $display("FAIL flush_mthi got %h want %h", rd, x); end
        step(1'b1, C_MULT, $urandom, $urandom, 1'b1);
        n_checks++; if (bus.dp_go !== 1'b0) begin n_fail++; $display("FAIL flush_launch dp_go got %b want 0", bus.dp_go); end
        end_test("flush_idle");
    endtask

    task automatic test_flush_busy();
        int st, k; logic [31:0] rd, h, l;
        begin_test();
        h = $urandom; l = $urandom;
        issue(C_MTHI, h, 32'd0, st, rd);
        issue(C_MTLO, l, 32'd0, st, rd);
        step(1'b1, C_MULT, $urandom, $urandom, 1'b0);
        k = $urandom_range(0, ML - 1);
        for (int i = 0; i < k; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step(1'b1, C_MFLO, 32'd0, 32'd0, 1'b1);
        n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL flush_busy_stall got %b want 0", obs_stall); end
        issue(C_MFLO, 32'd0, 32'd0, st, rd);
        n_checks++; if (st !== ML - k) begin n_fail++; $display("FAIL drain_stall_cycles k=%0d got %0d want %0d", k, st, ML - k); end
        n_checks++; if (rd !== l) begin n_fail++; $display("FAIL drain_lo got %h want %h", rd, l); end
        n_checks++; if (bus.hi_q !== h) begin n_fail++; $display("FAIL drain_hi got %h want %h", bus.hi_q, h); end
        end_test("flush_busy");
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] rd, a, b; logic [63:0] r;
        begin_test();
        a = $urandom; b = $urandom_range(1, 1000);
        r = ref_res(C_DIV, a, b);
        step(1'b1, C_MULT, $urandom, $urandom, 1'b0);
        issue(C_DIV, a, b, st, rd);
        n_checks++; if (st !== ML + 1) begin n_fail++; $display("FAIL b2b_div_stall got %0d want %0d", st, ML + 1); end
        n_checks++; if (bus.dp_m !== C_DIV || bus.dp_go !== 1'b1)
            begin n_fail++; $display("FAIL b2b_launch got m=%h go=%b want %h/1", bus.dp_m, bus.dp_go, C_DIV); end
        issue(C_MFLO, 32'd0, 32'd0, st, rd);
        n_checks++; if (rd !== r[31:0] || bus.hi_q !== r[63:32])
            begin n_fail++; $display("FAIL b2b_result got %h/%h want %h/%h", bus.hi_q, rd, r[63:32], r[31:0]); end
        end_test("back_to_back");
    endtask

    task automatic test_rst_mid();
        int st; logic [31:0] rd;
        begin_test();
        issue(C_MTHI, $urandom | 32'h1, 32'd0, st, rd);
        step(1'b1, C_DIV, $urandom, $urandom_range(1, 99), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        bus.op_valid = 1'b1; bus.op = C_MFHI; bus.flush = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.hi_q !== 32'd0 || bus.lo_q !== 32'd0)
            begin n_fail++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", bus.hi_q, bus.lo_q); end
        n_checks++; if (bus.stall !== 1'b0 || bus.rdata !== 32'd0)
            begin n_fail++; $display("FAIL rst_mid_stall got %b rdata %h want 0/0", bus.stall, bus.rdata); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < DL + 5; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        end_test("rst_mid");
    endtask

    task automatic test_random();
        logic v, fl; logic [3:0] op; logic [31:0] a, b;
        begin_test();
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 9) == 0) && !(m_busy && cyc == m_end - 1);
            step(v, op, a, b, fl);
        end
        end_test("random");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.op_valid = 1'b0; bus.op = 4'd0; bus.rs = '0; bus.rt = '0; bus.flush = 1'b0;
        bus.dp_hi = '0; bus.dp_lo = '0;
        model_reset();
        test_reset();
        test_mult_dep();
        test_div();
        test_mthi();
        test_flush_idle();
        test_flush_busy();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
